// File: rtl/scan_seq_ctrl.sv
// Scan test sequencer: shifts patterns through the scan chain, inserts
// scan-enable settling gaps around the capture window, counts patterns
// and finally unloads the last response.
module scan_seq_ctrl #(
  parameter int LEN_W = 8,
  parameter int PAT_W = 16
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] chain_len,
  input  logic [PAT_W-1:0] num_pat,
  input  logic [1:0]       cap_pulses,
  output logic             SE,
  output logic             GCK_EN,
  output logic             si_vld,
  output logic             so_vld,
  output logic             busy,
  output logic             done,
  output logic [PAT_W-1:0] pat_cnt,
  output logic [LEN_W-1:0] shift_cnt
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SHIFT   = 3'd1;
  localparam logic [2:0] ST_SE_FALL = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_SE_RISE = 3'd4;
  localparam logic [2:0] ST_UNLOAD  = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] shift_q, shift_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [1:0]       cap_cnt_q, cap_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PAT_W-1:0] npat_q, npat_d;
  logic [1:0]       ncap_q, ncap_d;
  logic [PAT_W-1:0] pat_inc;
  logic             shift_last;

  // pat_q never exceeds num_pat-1 before increment, so pat_q+1 cannot wrap
  assign pat_inc    = pat_q + PAT_W'(1);
  assign shift_last = (shift_q == len_q - LEN_W'(1));

  // Next-state, counter and configuration-latch logic; abort overrides all
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    pat_d     = pat_q;
    cap_cnt_d = cap_cnt_q;
    len_d     = len_q;
    npat_d    = npat_q;
    ncap_d    = ncap_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (chain_len != '0) && (num_pat != '0)) begin
          state_d   = ST_SHIFT;
          shift_d   = '0;
          pat_d     = '0;
          cap_cnt_d = '0;
          len_d     = chain_len;
          npat_d    = num_pat;
          ncap_d    = (cap_pulses == 2'd0) ? 2'd1 : cap_pulses;
        end
      end
      ST_SHIFT: begin
        if (shift_last) begin
          shift_d = '0;
          state_d = ST_SE_FALL;
        end else begin
          shift_d = shift_q + LEN_W'(1);
        end
      end
      ST_SE_FALL: begin
        cap_cnt_d = '0;
        state_d   = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (cap_cnt_q == ncap_q - 2'd1) begin
          cap_cnt_d = '0;
          state_d   = ST_SE_RISE;
        end else begin
          cap_cnt_d = cap_cnt_q + 2'd1;
        end
      end
      ST_SE_RISE: begin
        pat_d   = pat_inc;
        state_d = (pat_inc < npat_q) ? ST_SHIFT : ST_UNLOAD;
      end
      ST_UNLOAD: begin
        if (shift_last) begin
          shift_d = '0;
          state_d = ST_DONE;
        end else begin
          shift_d = shift_q + LEN_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      shift_d   = '0;
      cap_cnt_d = '0;
      pat_d     = pat_q;
    end
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge CK) begin
    if (!RN) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      pat_q     <= '0;
      cap_cnt_q <= '0;
      len_q     <= '0;
      npat_q    <= '0;
      ncap_q    <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      pat_q     <= pat_d;
      cap_cnt_q <= cap_cnt_d;
      len_q     <= len_d;
      npat_q    <= npat_d;
      ncap_q    <= ncap_d;
    end
  end

  // Outputs decoded purely from registered state
  assign SE        = (state_q == ST_SHIFT) || (state_q == ST_SE_RISE) ||
                     (state_q == ST_UNLOAD);
  assign GCK_EN    = (state_q == ST_SHIFT) || (state_q == ST_CAPTURE) ||
                     (state_q == ST_UNLOAD);
  assign si_vld    = (state_q == ST_SHIFT);
  assign so_vld    = ((state_q == ST_SHIFT) && (pat_q != '0)) ||
                     (state_q == ST_UNLOAD);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign pat_cnt   = pat_q;
  assign shift_cnt = shift_q;

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Directed bench for scan_seq_ctrl: cycle-exact table for a two-pattern
// session plus hand-written sequences for capture length, rejected starts,
// abort, mid-shift reset, start-while-busy and the maximum pattern count.
module tb_scan_seq_ctrl;

  localparam int LEN_W = 8;
  localparam int PAT_W = 4;

  logic             CK = 1'b0;
  logic             RN, start, abort;
  logic [LEN_W-1:0] chain_len;
  logic [PAT_W-1:0] num_pat;
  logic [1:0]       cap_pulses;
  logic             SE, GCK_EN, si_vld, so_vld, busy, done;
  logic [PAT_W-1:0] pat_cnt;
  logic [LEN_W-1:0] shift_cnt;

  int checks = 0;
  int errors = 0;

  scan_seq_ctrl #(.LEN_W(LEN_W), .PAT_W(PAT_W)) dut (
    .CK(CK), .RN(RN), .start(start), .abort(abort),
    .chain_len(chain_len), .num_pat(num_pat), .cap_pulses(cap_pulses),
    .SE(SE), .GCK_EN(GCK_EN), .si_vld(si_vld), .so_vld(so_vld),
    .busy(busy), .done(done), .pat_cnt(pat_cnt), .shift_cnt(shift_cnt)
  );

  always #5 CK = ~CK;

  typedef struct {
    logic st;
    logic se, gck, si, so, bsy, dn;
    int   pat, sh;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic st, logic se, logic gck, logic si, logic so,
                              logic bsy, logic dn, int pat, int sh);
    vec_t v;
    v.st = st; v.se = se; v.gck = gck; v.si = si; v.so = so;
    v.bsy = bsy; v.dn = dn; v.pat = pat; v.sh = sh;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_se"},   int'(SE), 0);
    chk({tag, "_gck"},  int'(GCK_EN), 0);
    chk({tag, "_si"},   int'(si_vld), 0);
    chk({tag, "_so"},   int'(so_vld), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  // Launch a session and measure it until busy falls (bounded)
  task automatic run_session(input string tag, input int l, input int n, input int cap,
                             input int exp_cap, input int exp_gap, input int exp_total);
    int cap_cyc, gap_cyc, total, done_cyc, guard;
    chain_len = LEN_W'(l); num_pat = PAT_W'(n); cap_pulses = 2'(cap);
    start = 1'b1;
    step();
    start = 1'b0;
    cap_cyc = 0; gap_cyc = 0; total = 0; done_cyc = 0; guard = 0;
    while (busy && guard < 300) begin
      total++;
      if (!SE && GCK_EN) cap_cyc++;
      if (!GCK_EN && !done) gap_cyc++;
      if (done) done_cyc++;
      step();
      guard++;
    end
    chk({tag, "_timeout"}, guard >= 300 ? 1 : 0, 0);
    chk({tag, "_capture_cycles"}, cap_cyc, exp_cap);
    chk({tag, "_gap_cycles"}, gap_cyc, exp_gap);
    chk({tag, "_busy_cycles"}, total, exp_total);
    chk({tag, "_done_cycles"}, done_cyc, 1);
    chk({tag, "_pat_cnt"}, int'(pat_cnt), n);
  endtask

  initial begin
    int guard;
    logic done_seen;

    // Two-pattern session, L=4 N=2 C=1; start pulsed again mid-session
    tbl[0]  = mk(1, 1,1,1,0, 1,0, 0,0);
    tbl[1]  = mk(0, 1,1,1,0, 1,0, 0,1);
    tbl[2]  = mk(0, 1,1,1,0, 1,0, 0,2);
    tbl[3]  = mk(0, 1,1,1,0, 1,0, 0,3);
    tbl[4]  = mk(0, 0,0,0,0, 1,0, 0,0);
    tbl[5]  = mk(0, 0,1,0,0, 1,0, 0,0);
    tbl[6]  = mk(0, 1,0,0,0, 1,0, 0,0);
    tbl[7]  = mk(0, 1,1,1,1, 1,0, 1,0);
    tbl[8]  = mk(1, 1,1,1,1, 1,0, 1,1);
    tbl[9]  = mk(0, 1,1,1,1, 1,0, 1,2);
    tbl[10] = mk(0, 1,1,1,1, 1,0, 1,3);
    tbl[11] = mk(0, 0,0,0,0, 1,0, 1,0);
    tbl[12] = mk(0, 0,1,0,0, 1,0, 1,0);
    tbl[13] = mk(0, 1,0,0,0, 1,0, 1,0);
    tbl[14] = mk(0, 1,1,0,1, 1,0, 2,0);
    tbl[15] = mk(0, 1,1,0,1, 1,0, 2,1);
    tbl[16] = mk(0, 1,1,0,1, 1,0, 2,2);
    tbl[17] = mk(0, 1,1,0,1, 1,0, 2,3);
    tbl[18] = mk(0, 0,0,0,0, 1,1, 2,0);
    tbl[19] = mk(0, 0,0,0,0, 0,0, 2,0);

    RN = 1'b0; start = 1'b1; abort = 1'b0;
    chain_len = 8'd4; num_pat = 4'd2; cap_pulses = 2'd1;
    step(); step();
    chk_idle_zero("reset");
    chk("reset_pat", int'(pat_cnt), 0);
    chk("reset_shift", int'(shift_cnt), 0);
    RN = 1'b1; start = 1'b0;
    step();

    for (int i = 0; i < 20; i++) begin
      start = tbl[i].st;
      step();
      chk($sformatf("v%0d_se", i),   int'(SE),        int'(tbl[i].se));
      chk($sformatf("v%0d_gck", i),  int'(GCK_EN),    int'(tbl[i].gck));
      chk($sformatf("v%0d_si", i),   int'(si_vld),    int'(tbl[i].si));
      chk($sformatf("v%0d_so", i),   int'(so_vld),    int'(tbl[i].so));
      chk($sformatf("v%0d_busy", i), int'(busy),      int'(tbl[i].bsy));
      chk($sformatf("v%0d_done", i), int'(done),      int'(tbl[i].dn));
      chk($sformatf("v%0d_pat", i),  int'(pat_cnt),   tbl[i].pat);
      chk($sformatf("v%0d_sh", i),   int'(shift_cnt), tbl[i].sh);
    end
    start = 1'b0;
    step();
    chk("idle_pat_hold", int'(pat_cnt), 2);

    // Capture length: 0 treated as 1, then 3
    run_session("cap0", 2, 1, 0, 1, 2, 8);
    run_session("cap3", 2, 1, 3, 3, 2, 10);

    // Rejected starts
    chain_len = 8'd0; num_pat = 4'd5; start = 1'b1;
    step(); step();
    chk("len0_busy", int'(busy), 0);
    chain_len = 8'd5; num_pat = 4'd0;
    step(); step();
    chk("npat0_busy", int'(busy), 0);
    start = 1'b0;

    // Abort during the second CAPTURE of a three-pattern session
    chain_len = 8'd2; num_pat = 4'd3; cap_pulses = 2'd1; start = 1'b1;
    step();
    start = 1'b0;
    guard = 0; done_seen = 1'b0;
    while (!(!SE && GCK_EN && pat_cnt == 4'd1) && guard < 40) begin
      if (done) done_seen = 1'b1;
      step();
      guard++;
    end
    chk("abort_wait_timeout", guard >= 40 ? 1 : 0, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_se", int'(SE), 0);
    chk("abort_gck", int'(GCK_EN), 0);
    chk("abort_pat", int'(pat_cnt), 1);
    chk("abort_shift", int'(shift_cnt), 0);
    if (done) done_seen = 1'b1;
    step();
    if (done) done_seen = 1'b1;
    chk("abort_no_done", int'(done_seen), 0);
    chk("abort_stays_idle", int'(busy), 0);

    // Reset mid-SHIFT with shift_cnt=2, then a full rerun
    chain_len = 8'd4; num_pat = 4'd2; cap_pulses = 2'd1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("pre_rst_shift", int'(shift_cnt), 2);
    RN = 1'b0; start = 1'b1; abort = 1'b1;
    step();
    RN = 1'b1; start = 1'b0; abort = 1'b0;
    chk_idle_zero("midrst");
    chk("midrst_pat", int'(pat_cnt), 0);
    chk("midrst_shift", int'(shift_cnt), 0);
    step();
    chk("midrst_still_idle", int'(busy), 0);
    run_session("rerun", 4, 2, 1, 2, 4, 19);

    // Start held high through DONE: one IDLE cycle, then a new session
    chain_len = 8'd2; num_pat = 4'd1; cap_pulses = 2'd1; start = 1'b1;
    step();
    guard = 0;
    while (!done && guard < 30) begin
      step();
      guard++;
    end
    chk("held_done_timeout", guard >= 30 ? 1 : 0, 0);
    step();
    chk("held_idle_busy", int'(busy), 0);
    step();
    chk("held_restart_busy", int'(busy), 1);
    chk("held_restart_si", int'(si_vld), 1);
    chk("held_restart_so", int'(so_vld), 0);
    chk("held_restart_pat", int'(pat_cnt), 0);
    start = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    chk("held_abort_busy", int'(busy), 0);

    // Maximum pattern count for PAT_W=4: no wrap of pat_cnt
    run_session("maxpat", 1, 15, 1, 15, 30, 62);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_seq_ctrl.md
SCAN_SEQ_CTRL -- requirements
Module: scan_seq_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 8, width of chain_len and shift_cnt.
REQ-002 SHALL have parameter PAT_W, default 16, width of num_pat and pat_cnt.
REQ-003 SHALL have port CK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RN  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  request to run a test session; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  terminate the session.
REQ-007 SHALL have port chain_len  input  LEN_W  shift cycles per load; latched when start is accepted.
REQ-008 SHALL have port num_pat  input  PAT_W  number of patterns; latched when start is accepted.
REQ-009 SHALL have port cap_pulses  input  2  capture clock count; latched when start is accepted; 0 is treated as 1.
REQ-010 SHALL have port SE  output  1  scan enable to all SDFF SE pins.
REQ-011 SHALL have port GCK_EN  output  1  enable to the CLKGATE E pin of the scan clock.
REQ-012 SHALL have port si_vld  output  1  tester scan-in data is consumed this cycle.
REQ-013 SHALL have port so_vld  output  1  scan-out data is valid for compare this cycle.
REQ-014 SHALL have ports busy  output  1, done  output  1, pat_cnt  output  PAT_W, shift_cnt  output  LEN_W.

Function
REQ-015 SHALL implement the FSM states IDLE, SHIFT, SE_FALL, CAPTURE, SE_RISE, UNLOAD and DONE.
REQ-016 SHALL go from IDLE to SHIFT when start=1, chain_len!=0 and num_pat!=0; otherwise it SHALL ignore start.
REQ-017 SHALL clear pat_cnt and shift_cnt on accepting start.
REQ-018 SHALL drive SHIFT for exactly chain_len cycles: SE=1, GCK_EN=1, si_vld=1, and so_vld=1 only when pat_cnt!=0.
REQ-019 SHALL count shift_cnt 0..chain_len-1 in SHIFT and UNLOAD, return it to 0 on exit, and keep it 0 elsewhere.
REQ-020 SHALL hold SE_FALL for 1 cycle with SE=0 and GCK_EN=0, which is the scan-enable settling gap.
REQ-021 SHALL hold CAPTURE for max(cap_pulses,1) cycles with SE=0 and GCK_EN=1.
REQ-022 SHALL hold SE_RISE for 1 cycle with SE=1 and GCK_EN=0, and SHALL increment pat_cnt by 1 in that cycle.
REQ-023 SHALL leave SE_RISE for SHIFT when the incremented pat_cnt<num_pat, and for UNLOAD otherwise.
REQ-024 SHALL drive UNLOAD for chain_len cycles: SE=1, GCK_EN=1, si_vld=0, so_vld=1.
REQ-025 SHALL hold DONE for 1 cycle with done=1 and SE=0, then go to IDLE.
REQ-026 SHALL drive busy=1 in every state except IDLE.
REQ-027 SHALL hold pat_cnt in IDLE until the next accepted start.
REQ-028 SHALL drive SE=0, GCK_EN=0, si_vld=0 and so_vld=0 in IDLE.
REQ-029 SHALL go from any non-IDLE state to IDLE on the next edge when abort=1, without asserting done; pat_cnt SHALL hold its value.
REQ-030 SHALL give abort priority over all other transitions.
REQ-031 SHALL ignore start while busy=1.
REQ-032 SHALL run N*(L+2+C)+L+1 non-IDLE cycles per session, where N=num_pat, L=chain_len, C=max(cap_pulses,1).
REQ-033 SHALL make the first SHIFT cycle the cycle after start is sampled.
REQ-034 SHALL make all outputs registered, or decoded from state registers only, with no combinational path from inputs to outputs.
REQ-035 SHALL make pat_cnt stop at num_pat, with no wrap; num_pat=2^PAT_W-1 SHALL be supported.

Reset
REQ-036 SHALL, when RN=0 at a CK edge, move to IDLE with SE=0, GCK_EN=0, si_vld=0, so_vld=0, busy=0, done=0, pat_cnt=0, shift_cnt=0 and the latched configuration cleared.
REQ-037 SHALL apply reset in any state, including mid-SHIFT, and reset SHALL take priority over abort and start.

Verification
REQ-038 SHALL cover: L=4, N=2, cap=1, start at cycle 0 -> SHIFT 1-4, SE_FALL 5, CAPTURE 6, SE_RISE 7, SHIFT 8-11 (so_vld=1), SE_FALL 12, CAPTURE 13, SE_RISE 14, UNLOAD 15-18, done=1 at 19, pat_cnt=2, busy=0 at 20.
REQ-039 SHALL cover: cap_pulses=0 and then 3, with L=2, N=1 -> CAPTURE lasts 1 and 3 cycles; GCK_EN=0 in both gap cycles.
REQ-040 SHALL cover: start with chain_len=0 or num_pat=0 -> FSM stays IDLE and busy stays 0.
REQ-041 SHALL cover: abort during the second CAPTURE, N=3 -> IDLE next cycle, done never asserted, pat_cnt=1, SE=0.
REQ-042 SHALL cover: RN=0 during SHIFT with shift_cnt=2 -> every output at its reset value after the edge; a later start re-runs the full session.
REQ-043 SHALL cover: start pulsed while busy, and start held high through DONE -> the mid-session start is ignored, and a new session begins the cycle after IDLE is re-entered.
